// File: rtl/am_envelope_demod_if.sv
// Sample stream in, decimated envelope results out, grouped for the AM demodulator.
// No latency of its own; the demodulator side (slave) defines timing.
// No backpressure: in_valid is accepted every cycle, out_valid is a one-cycle pulse.
interface am_envelope_demod_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_sample;
    logic                    out_valid;
    logic signed [OUT_W-1:0] env_out;
    logic signed [OUT_W-1:0] env_ac;
    logic                    sat_flag;

    modport master (
        output in_valid,
        output in_sample,
        input  out_valid,
        input  env_out,
        input  env_ac,
        input  sat_flag
    );

    modport slave (
        input  in_valid,
        input  in_sample,
        output out_valid,
        output env_out,
        output env_ac,
        output sat_flag
    );
endinterface

// File: rtl/am_envelope_demod.sv
// AM envelope detector: rectify, integrate-and-dump over 2^LOG2_DECIM samples, DC-block.
// Latency: last sample of a block captured at edge k, out_valid high after edge k+2.
// No backpressure: every in_valid sample is consumed; gaps simply pause the block count.
module am_envelope_demod #(
    parameter int IN_W       = 32,
    parameter int LOG2_DECIM = 6,
    parameter int DC_SHIFT   = 4,
    parameter int OUT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    am_envelope_demod_if.slave    bus
);
    localparam int RECT_W = IN_W - 1;
    localparam int ACC_W  = RECT_W + LOG2_DECIM;
    localparam int DC_W   = IN_W + 2;

    localparam logic [IN_W-1:0]       IN_ONE  = IN_W'(1);
    localparam logic [LOG2_DECIM-1:0] CNT_MAX = '1;
    localparam logic [LOG2_DECIM-1:0] CNT_ONE = LOG2_DECIM'(1);
    localparam logic [RECT_W-1:0]     ENV_MAX = RECT_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [DC_W-1:0] AC_MAX = DC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [DC_W-1:0] AC_MIN = ~AC_MAX;

    logic [RECT_W-1:0]       rect_q, rect_d;
    logic                    rect_valid_q, rect_valid_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic [RECT_W-1:0]       avg_q, avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic signed [DC_W-1:0]  dc_est_q, dc_est_d;
    logic signed [OUT_W-1:0] env_out_q, env_out_d;
    logic signed [OUT_W-1:0] env_ac_q, env_ac_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sat_flag_q, sat_flag_d;

    logic [IN_W-1:0]         raw;
    logic [IN_W-1:0]         mag;
    logic [RECT_W-1:0]       rect_val;
    logic [ACC_W-1:0]        sum;
    logic signed [DC_W-1:0]  diff;
    logic                    env_sat;
    logic                    ac_hi;
    logic                    ac_lo;
    logic                    unused_sum_lsbs;

    assign unused_sum_lsbs = ^sum[LOG2_DECIM-1:0];

    always_comb begin
        raw = bus.in_sample;
        mag = raw[IN_W-1] ? (~raw + IN_ONE) : raw;
        // Only the most negative input still has its top bit set after negation.
        rect_val = mag[IN_W-1] ? '1 : mag[RECT_W-1:0];
        sum      = acc_q + {{LOG2_DECIM{1'b0}}, rect_q};
        diff     = $signed({3'b000, avg_q}) - dc_est_q;
        env_sat  = (avg_q > ENV_MAX);
        ac_hi    = (diff > AC_MAX);
        ac_lo    = (diff < AC_MIN);

        rect_d       = rect_q;
        rect_valid_d = bus.in_valid;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        avg_d        = avg_q;
        avg_valid_d  = 1'b0;
        dc_est_d     = dc_est_q;
        env_out_d    = env_out_q;
        env_ac_d     = env_ac_q;
        out_valid_d  = 1'b0;
        sat_flag_d   = sat_flag_q;

        if (bus.in_valid) begin
            rect_d = rect_val;
        end

        if (rect_valid_q) begin
            if (cnt_q == CNT_MAX) begin
                avg_d       = sum[ACC_W-1:LOG2_DECIM];
                acc_d       = '0;
                cnt_d       = '0;
                avg_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (avg_valid_q) begin
            env_out_d = env_sat ? OUT_W'(ENV_MAX) : avg_q[OUT_W-1:0];
            if (ac_hi) begin
                env_ac_d = AC_MAX[OUT_W-1:0];
            end else if (ac_lo) begin
                env_ac_d = AC_MIN[OUT_W-1:0];
            end else begin
                env_ac_d = diff[OUT_W-1:0];
            end
            // Leaky integrator: arithmetic shift floors toward minus infinity.
            dc_est_d    = dc_est_q + (diff >>> DC_SHIFT);
            out_valid_d = 1'b1;
            sat_flag_d  = sat_flag_q | env_sat | ac_hi | ac_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_q       <= '0;
            rect_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            avg_q        <= '0;
            avg_valid_q  <= 1'b0;
            dc_est_q     <= '0;
            env_out_q    <= '0;
            env_ac_q     <= '0;
            out_valid_q  <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            rect_q       <= rect_d;
            rect_valid_q <= rect_valid_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            avg_q        <= avg_d;
            avg_valid_q  <= avg_valid_d;
            dc_est_q     <= dc_est_d;
            env_out_q    <= env_out_d;
            env_ac_q     <= env_ac_d;
            out_valid_q  <= out_valid_d;
            sat_flag_q   <= sat_flag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.env_out   = env_out_q;
    assign bus.env_ac    = env_ac_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_am_envelope_demod.sv
// Bench for am_envelope_demod: directed steps plus random samples against a block-mean model.
// Expected results are queued per block with their due cycle; a negedge monitor checks each pulse.
// No backpressure to model: the bench drives at most one sample per cycle.
module tb_am_envelope_demod;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    am_envelope_demod_if #(.IN_W(32), .OUT_W(16)) bus ();

    am_envelope_demod #(
        .IN_W(32), .LOG2_DECIM(6), .DC_SHIFT(4), .OUT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint env_out;
        longint env_ac;
        longint sat;
        int     due_cyc;
    } exp_t;

    int     n_chk = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     pulses = 0;
    int     blocks = 0;
    longint blk_sum;
    int     blk_n;
    longint dc_m;
    bit     sat_m;
    exp_t   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function void model_reset();
        blocks  = blocks - exp_q.size();
        exp_q.delete();
        blk_sum = 0;
        blk_n   = 0;
        dc_m    = 0;
        sat_m   = 0;
    endfunction

    // Reference: block mean of |x| (clipped to 2^31-1), floor-leaky DC estimate, clamped outputs.
    function void model_sample(input int s, input int cap_cyc);
        longint a, avg, diff, eo, ea;
        exp_t   e;
        a = (s < 0) ? -longint'(s) : longint'(s);
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        blk_sum += a;
        blk_n++;
        if (blk_n == 64) begin
            avg  = blk_sum / 64;
            eo   = (avg > 32767) ? 32767 : avg;
            diff = avg - dc_m;
            ea   = (diff > 32767) ? 32767 : ((diff < -32768) ? -32768 : diff);
            if (diff >= 0) dc_m += diff / 16;
            else           dc_m -= (-diff + 15) / 16;
            sat_m = sat_m | (avg > 32767) | (diff > 32767) | (diff < -32768);
            e.env_out = eo;
            e.env_ac  = ea;
            e.sat     = sat_m;
            e.due_cyc = cap_cyc + 2;
            exp_q.push_back(e);
            blocks++;
            blk_sum = 0;
            blk_n   = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1) begin
            exp_t e;
            pulses++;
            chk("pulse_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.due_cyc);
                chk("env_out", bus.env_out, e.env_out);
                chk("env_ac", bus.env_ac, e.env_ac);
                chk("sat_flag", bus.sat_flag, e.sat);
            end
        end
    end

    task automatic drive(input bit v, input int s);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_sample = s;
        if (v) model_sample(s, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_env_out"}, bus.env_out, 0);
        chk({tag, "_env_ac"}, bus.env_ac, 0);
        chk({tag, "_sat_flag"}, bus.sat_flag, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int s;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Constant -1000: envelope 1000, AC part decays as the DC estimate settles.
        for (int i = 0; i < 192; i++) drive(1'b1, -1000);
        idle(4);
        chk("t2_env_out", bus.env_out, 1000);
        chk("t2_env_ac_blk3", bus.env_ac, 880);

        do_reset("midrun");

        for (int i = 0; i < 64; i++) drive(1'b1, (i % 2 == 0) ? 20000 : -20000);
        idle(4);
        chk("t3_alt_env_out", bus.env_out, 20000);
        for (int i = 0; i < 63; i++) drive(1'b1, 0);
        drive(1'b1, 127);
        idle(4);
        chk("t3_trunc_env_out", bus.env_out, 1);

        // Most negative input saturates; sat_flag must stick through a clean block.
        for (int i = 0; i < 64; i++) drive(1'b1, int'(32'h8000_0000));
        idle(4);
        chk("t4_env_out", bus.env_out, 32767);
        chk("t4_env_ac", bus.env_ac, 32767);
        chk("t4_sat", bus.sat_flag, 1);
        for (int i = 0; i < 64; i++) drive(1'b1, 1000);
        idle(4);
        chk("t4_sat_sticky", bus.sat_flag, 1);

        p0 = pulses;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 5000);
            drive(1'b0, 0);
        end
        idle(4);
        chk("t5_pulse_count", pulses - p0, 1);
        chk("t5_env_out", bus.env_out, 5000);

        for (int i = 0; i < 30; i++) drive(1'b1, 9999);
        do_reset("partial");
        p0 = pulses;
        for (int i = 0; i < 64; i++) drive(1'b1, 300);
        idle(4);
        chk("t6_pulse_count", pulses - p0, 1);
        chk("t6_env_out", bus.env_out, 300);
        chk("t6_env_ac", bus.env_ac, 300);
        chk("t6_sat", bus.sat_flag, 0);

        for (int i = 0; i < 600; i++) begin
            if (i < 250) s = int'($urandom);
            else         s = int'($urandom_range(0, 40000)) - 20000;
            drive($urandom_range(0, 3) != 0, s);
        end
        idle(6);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("total_pulses", pulses, blocks);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/am_envelope_demod.md
Name: am_envelope_demod

Overview:
AM envelope detector: the receive-side counterpart of the team's NCO-based AM modulator.
- Consumes signed AM samples and full-wave rectifies them.
- Integrates and dumps over 2^LOG2_DECIM valid samples, i.e. a boxcar low-pass with decimation.
- Emits the recovered envelope, plus a DC-blocked (AC) envelope from a leaky-integrator DC estimator.
- Sits downstream of the modulator output (32-bit signed) in the AM loopback chain.

Parameters:
IN_W, 32, input sample width (signed).
LOG2_DECIM, 6, log2 of samples per output block (DECIM = 64).
DC_SHIFT, 4, DC-estimator leak shift (alpha = 2^-DC_SHIFT).
OUT_W, 16, output width (signed, saturating).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  qualifies in_sample; gaps allowed; no backpressure.
in_sample  in  IN_W  signed AM sample.
out_valid  out  1  one-cycle pulse per completed block.
env_out  out  OUT_W  signed recovered envelope (block mean of |x|), saturated to +2^(OUT_W-1)-1.
env_ac  out  OUT_W  signed envelope minus DC estimate, saturated both ways.
sat_flag  out  1  sticky: any env_out/env_ac saturation since reset.

Behaviour:
- Reset (async, rst=1):
  - Outputs: env_out, env_ac, out_valid and sat_flag go to 0.
  - Internal state: rect, rect_valid, acc, cnt, avg, avg_valid and dc_est go to 0.
  - Reset mid-block discards the partial block; counting restarts at 0.
- Stage 1, edge where in_valid=1:
  - rect <= |in_sample| as unsigned IN_W-1 bits; in_sample = -2^(IN_W-1) maps to 2^(IN_W-1)-1.
  - rect_valid <= in_valid every edge.
- Stage 2, acc unsigned IN_W-1+LOG2_DECIM bits, cnt LOG2_DECIM bits. On rect_valid:
  - cnt < DECIM-1: acc <= acc+rect; cnt <= cnt+1.
  - cnt == DECIM-1: avg <= (acc+rect) >> LOG2_DECIM (truncating); acc <= 0; cnt <= 0; avg_valid <= 1.
  - No overflow is possible: worst case (2^(IN_W-1)-1)*DECIM fits.
  - avg_valid is 0 on all other edges.
- Stage 3, on avg_valid:
  - env_out <= min(avg, 2^(OUT_W-1)-1).
  - diff = avg - dc_est, where dc_est is signed, IN_W+2 bits, and the old value is used.
  - env_ac <= diff saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - dc_est <= dc_est + (diff >>> DC_SHIFT) (arithmetic, floor).
  - out_valid <= 1 for exactly one cycle.
  - sat_flag <= 1 if either output saturated.
- Between blocks: env_out and env_ac hold their last values; out_valid = 0.
- Latency: the final sample of a block is captured at edge k; out_valid is high in the cycle following edge k+2.
  - Throughput: one out_valid per DECIM valid samples.
  - in_valid=0 cycles do not advance cnt.
- First block: dc_est = 0, so env_ac = env_out (if unsaturated).
- sat_flag clears only on rst.

Test Plan:
1. Assert rst mid-run -> env_out=0, env_ac=0, out_valid=0, sat_flag=0 immediately (asynchronous).
2. in_sample=-1000 on every cycle, defaults:
   - First out_valid two cycles after the 64th capture edge: env_out=1000, env_ac=1000.
   - Second block: env_out=1000, env_ac=938 (dc_est=62).
   - Third block: env_ac=880 (dc_est=120).
3. Alternating +20000/-20000 for 64 samples -> env_out=20000; 63 zeros then one 127 -> env_out=1 (truncation).
4. One block of in_sample=-2^31 -> env_out=32767, env_ac=32767, sat_flag=1 and staying 1 through later unsaturated blocks.
5. in_valid toggling 1/0 with constant 5000 -> out_valid only after 64 valid samples (about 128 cycles); env_out=5000; no extra pulses.
6. rst after 30 of 64 samples, then 64 samples of 300 -> single out_valid with env_out=300; no partial-block output.
